// File: rtl/mem_access_unit.sv
// ----------------------------------------------------------------------------
// mem_access_unit
//
// Purpose: MEM pipeline stage. It issues one word access at a time to the data
// memory, holds the upstream pipeline while a load or store is outstanding,
// and registers the MEM/WB writeback (ALU result or load data).
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   ALUOutIn                      EX/MEM ALU result, also the byte address
//   RdDataBIn                     EX/MEM store data
//   IsLoadInsnIn, IsStoreInsnIn   memory-operation flags (never both set)
//   RdWrEnableIn, IsDstRtIn       register write enable, dest select (1 = RT)
//   RTIn, RDIn                    candidate destination registers
//   dmemReq, dmemWe               memory request, write strobe (qualified by req)
//   dmemAddr, dmemWrData          registered request address / write data
//   dmemAck, dmemRdData           completion, read data valid with ack
//   StallOut                      combinational hold to IF/ID/EX and EX/MEM
//   WbDataOut, WbRegOut, WbEnableOut  registered MEM/WB writeback
//   MemErrOut                     sticky access-timeout flag
//
// Configuration:
//   MEM_TIMEOUT_EN  when defined, an access with no ack is abandoned on its
//                   255th BUSY cycle and MemErrOut latches. When undefined the
//                   unit waits forever and MemErrOut is tied low.
// ----------------------------------------------------------------------------
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ALUOutIn,
    input  logic [31:0] RdDataBIn,
    input  logic        IsLoadInsnIn,
    input  logic        IsStoreInsnIn,
    input  logic        RdWrEnableIn,
    input  logic        IsDstRtIn,
    input  logic [4:0]  RTIn,
    input  logic [4:0]  RDIn,
    output logic        dmemReq,
    output logic        dmemWe,
    output logic [31:0] dmemAddr,
    output logic [31:0] dmemWrData,
    input  logic        dmemAck,
    input  logic [31:0] dmemRdData,
    output logic        StallOut,
    output logic [31:0] WbDataOut,
    output logic [4:0]  WbRegOut,
    output logic        WbEnableOut,
    output logic        MemErrOut
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } stateT;

    stateT      curState;
    stateT      nextState;

    logic       memOp;       // a load or store sits in EX/MEM
    logic       issue;       // launch a new access this cycle
    logic       ackEvt;      // the outstanding access completes this cycle
    logic       timeoutEvt;  // the outstanding access is abandoned this cycle
    logic [4:0] dstReg;
    logic       wbEnSel;

    assign memOp   = IsLoadInsnIn | IsStoreInsnIn;
    assign dstReg  = IsDstRtIn ? RTIn : RDIn;
    // Writes to register 0 are architecturally discarded, so never enable them.
    assign wbEnSel = RdWrEnableIn & (dstReg != 5'd0);

`ifdef MEM_TIMEOUT_EN
    logic [7:0] busyCnt;

    // Count cycles of the current BUSY episode; restarts at each new request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busyCnt <= 8'd0;
        end else if (issue) begin
            busyCnt <= 8'd0;
        end else if (curState == BUSY) begin
            busyCnt <= busyCnt + 8'd1;
        end
    end

    // busyCnt is 0 in the first BUSY cycle, so 254 marks the 255th one.
    assign timeoutEvt = (curState == BUSY) & ~dmemAck & (busyCnt == 8'd254);

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            MemErrOut <= 1'b0;
        end else if (timeoutEvt) begin
            MemErrOut <= 1'b1;
        end
    end
`else
    assign timeoutEvt = 1'b0;
    assign MemErrOut  = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            curState <= IDLE;
        end else begin
            curState <= nextState;
        end
    end

    // FSM next-state logic.
    always_comb begin
        nextState = curState;
        case (curState)
            IDLE: begin
                if (memOp) begin
                    nextState = BUSY;
                end else begin
                    nextState = IDLE;
                end
            end
            BUSY: begin
                if (dmemAck | timeoutEvt) begin
                    nextState = IDLE;
                end else begin
                    nextState = BUSY;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // FSM outputs: issue/complete strobes and the pipeline hold.
    always_comb begin
        issue  = 1'b0;
        ackEvt = 1'b0;
        case (curState)
            IDLE:    issue  = memOp;      // an ack seen in IDLE is ignored
            BUSY:    ackEvt = dmemAck;
            default: begin
                issue  = 1'b0;
                ackEvt = 1'b0;
            end
        endcase
        StallOut = memOp & ~(ackEvt | timeoutEvt);
    end

    // Memory request registers: captured at issue, held until ack or timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmemReq    <= 1'b0;
            dmemWe     <= 1'b0;
            dmemAddr   <= 32'd0;
            dmemWrData <= 32'd0;
        end else if (issue) begin
            dmemReq    <= 1'b1;
            dmemWe     <= IsStoreInsnIn;
            dmemAddr   <= ALUOutIn;      // bits [1:0] pass through untouched
            dmemWrData <= RdDataBIn;
        end else if (ackEvt | timeoutEvt) begin
            dmemReq    <= 1'b0;
            dmemWe     <= 1'b0;
        end
    end

    // MEM/WB register: bubble while stalled, load data on ack, ALU result otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            WbDataOut   <= 32'd0;
            WbRegOut    <= 5'd0;
            WbEnableOut <= 1'b0;
        end else if (StallOut) begin
            WbEnableOut <= 1'b0;
        end else if (ackEvt & IsLoadInsnIn) begin
            WbDataOut   <= dmemRdData;
            WbRegOut    <= dstReg;
            WbEnableOut <= wbEnSel;
        end else if (memOp) begin
            // Store completion or abandoned access: nothing to write back.
            WbEnableOut <= 1'b0;
        end else begin
            WbDataOut   <= ALUOutIn;
            WbRegOut    <= dstReg;
            WbEnableOut <= wbEnSel;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// ----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Self-checking bench for mem_access_unit: a table of ALU-style instructions
// with hand-computed writeback results, then directed load/store sequences
// for multi-cycle accesses, reset during an access and the BUSY wait limit.
// ----------------------------------------------------------------------------
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic [31:0] ALUOutIn;
    logic [31:0] RdDataBIn;
    logic        IsLoadInsnIn;
    logic        IsStoreInsnIn;
    logic        RdWrEnableIn;
    logic        IsDstRtIn;
    logic [4:0]  RTIn;
    logic [4:0]  RDIn;
    logic        dmemReq;
    logic        dmemWe;
    logic [31:0] dmemAddr;
    logic [31:0] dmemWrData;
    logic        dmemAck;
    logic [31:0] dmemRdData;
    logic        StallOut;
    logic [31:0] WbDataOut;
    logic [4:0]  WbRegOut;
    logic        WbEnableOut;
    logic        MemErrOut;

    mem_access_unit dut (
        .clk          (clk),
        .rst          (rst),
        .ALUOutIn     (ALUOutIn),
        .RdDataBIn    (RdDataBIn),
        .IsLoadInsnIn (IsLoadInsnIn),
        .IsStoreInsnIn(IsStoreInsnIn),
        .RdWrEnableIn (RdWrEnableIn),
        .IsDstRtIn    (IsDstRtIn),
        .RTIn         (RTIn),
        .RDIn         (RDIn),
        .dmemReq      (dmemReq),
        .dmemWe       (dmemWe),
        .dmemAddr     (dmemAddr),
        .dmemWrData   (dmemWrData),
        .dmemAck      (dmemAck),
        .dmemRdData   (dmemRdData),
        .StallOut     (StallOut),
        .WbDataOut    (WbDataOut),
        .WbRegOut     (WbRegOut),
        .WbEnableOut  (WbEnableOut),
        .MemErrOut    (MemErrOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        dstRt;
        logic        wrEn;
        logic [31:0] expData;
        logic [4:0]  expReg;
        logic        expEn;
    } aluVecT;

    aluVecT vecs[6];

    int nChecks = 0;
    int nPass   = 0;

    // Results of the most recent memTxn call.
    int          txReq;
    int          txStall;
    logic        txDone;
    logic        txStable;
    logic        txWe;
    logic [31:0] txAddr;
    logic [31:0] txWd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) begin
            nPass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clearOps();
        IsLoadInsnIn  = 1'b0;
        IsStoreInsnIn = 1'b0;
    endtask

    // Called just after a falling edge. Presents a load/store, answers the
    // request with ack in its ackDelay-th request cycle, and returns #1 after
    // the ack edge (or after a 20-cycle bound).
    task automatic memTxn(input logic isLoad, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] rt, input logic [4:0] rd, input logic dstRt,
                          input logic wrEn, input int ackDelay, input logic [31:0] rdData);
        IsLoadInsnIn  = isLoad;
        IsStoreInsnIn = ~isLoad;
        ALUOutIn      = addr;
        RdDataBIn     = wdata;
        RTIn          = rt;
        RDIn          = rd;
        IsDstRtIn     = dstRt;
        RdWrEnableIn  = wrEn;
        txReq = 0; txStall = 0; txDone = 1'b0; txStable = 1'b1;
        txWe = 1'b0; txAddr = 32'h0; txWd = 32'h0;
        for (int c = 0; c < 20; c++) begin
            if (dmemReq) begin
                if (txReq == 0) begin
                    txAddr = dmemAddr;
                    txWd   = dmemWrData;
                    txWe   = dmemWe;
                end else if (dmemAddr !== txAddr || dmemWrData !== txWd || dmemWe !== txWe) begin
                    txStable = 1'b0;
                end
                txReq++;
            end
            dmemAck    = dmemReq && (txReq == ackDelay);
            dmemRdData = dmemAck ? rdData : 32'h0;
            #1;
            if (StallOut) txStall++;
            txDone = dmemAck;
            @(posedge clk);
            #1;
            dmemAck    = 1'b0;
            dmemRdData = 32'h0;
            if (txDone) break;
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b0;
        ALUOutIn = 32'h0; RdDataBIn = 32'h0; RdWrEnableIn = 1'b0; IsDstRtIn = 1'b0;
        RTIn = 5'd0; RDIn = 5'd0; dmemAck = 1'b0; dmemRdData = 32'h0;
        clearOps();

        vecs[0] = '{32'h0000_1234, 5'd0,  5'd5,  1'b0, 1'b1, 32'h0000_1234, 5'd5,  1'b1};
        vecs[1] = '{32'hFFFF_FFFF, 5'd9,  5'd3,  1'b1, 1'b1, 32'hFFFF_FFFF, 5'd9,  1'b1};
        vecs[2] = '{32'h0000_0055, 5'd4,  5'd0,  1'b0, 1'b1, 32'h0000_0055, 5'd0,  1'b0};
        vecs[3] = '{32'h0000_CAFE, 5'd1,  5'd12, 1'b0, 1'b0, 32'h0000_CAFE, 5'd12, 1'b0};
        vecs[4] = '{32'h8000_0003, 5'd31, 5'd2,  1'b1, 1'b1, 32'h8000_0003, 5'd31, 1'b1};
        vecs[5] = '{32'h0BAD_0001, 5'd0,  5'd4,  1'b1, 1'b1, 32'h0BAD_0001, 5'd0,  1'b0};

        // Reset acts without a clock edge.
        #2 rst = 1'b1;
        #1;
        check("rstReq",    dmemReq,     32'h0);
        check("rstWe",     dmemWe,      32'h0);
        check("rstAddr",   dmemAddr,    32'h0);
        check("rstWrData", dmemWrData,  32'h0);
        check("rstWbData", WbDataOut,   32'h0);
        check("rstWbReg",  WbRegOut,    32'h0);
        check("rstWbEn",   WbEnableOut, 32'h0);
        check("rstErr",    MemErrOut,   32'h0);
        check("rstStall",  StallOut,    32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Non-memory instructions: one-cycle writeback, never a stall.
        for (int i = 0; i < 6; i++) begin
            ALUOutIn     = vecs[i].alu;
            RTIn         = vecs[i].rt;
            RDIn         = vecs[i].rd;
            IsDstRtIn    = vecs[i].dstRt;
            RdWrEnableIn = vecs[i].wrEn;
            #1;
            check($sformatf("aluStall%0d", i), StallOut, 32'h0);
            @(posedge clk);
            #1;
            check($sformatf("aluWbData%0d", i), WbDataOut,   vecs[i].expData);
            check($sformatf("aluWbReg%0d", i),  WbRegOut,    32'(vecs[i].expReg));
            check($sformatf("aluWbEn%0d", i),   WbEnableOut, 32'(vecs[i].expEn));
            check($sformatf("aluReq%0d", i),    dmemReq,     32'h0);
            @(negedge clk);
        end

        // Load, ack in the third request cycle.
        memTxn(1'b1, 32'h0000_0100, 32'h0, 5'd7, 5'd1, 1'b1, 1'b1, 3, 32'hDEAD_BEEF);
        check("ldDone",   txDone,      32'h1);
        check("ldReqCyc", txReq,       32'd3);
        check("ldStall",  txStall,     32'd3);
        check("ldAddr",   txAddr,      32'h0000_0100);
        check("ldWe",     txWe,        32'h0);
        check("ldStable", txStable,    32'h1);
        check("ldReqOff", dmemReq,     32'h0);
        check("ldWbData", WbDataOut,   32'hDEAD_BEEF);
        check("ldWbReg",  WbRegOut,    32'd7);
        check("ldWbEn",   WbEnableOut, 32'h1);
        @(negedge clk);
        clearOps();

        // Store, ack in the first request cycle; unaligned address bits pass through.
        memTxn(1'b0, 32'h0000_0040, 32'hA5A5_A5A5, 5'd1, 5'd6, 1'b0, 1'b1, 1, 32'h0);
        check("stDone",   txDone,      32'h1);
        check("stReqCyc", txReq,       32'd1);
        check("stStall",  txStall,     32'd1);
        check("stAddr",   txAddr,      32'h0000_0040);
        check("stWd",     txWd,        32'hA5A5_A5A5);
        check("stWe",     txWe,        32'h1);
        check("stWbEn",   WbEnableOut, 32'h0);
        check("stWeOff",  dmemWe,      32'h0);
        @(negedge clk);
        clearOps();

        memTxn(1'b0, 32'h0000_0043, 32'h1357_9BDF, 5'd1, 5'd6, 1'b0, 1'b0, 2, 32'h0);
        check("st2Addr",  txAddr,  32'h0000_0043);
        check("st2Stable", txStable, 32'h1);
        @(negedge clk);
        clearOps();

        // Load to register 0: data still registered, enable forced low.
        memTxn(1'b1, 32'h0000_0200, 32'h0, 5'd9, 5'd0, 1'b0, 1'b1, 2, 32'h0000_0011);
        check("ldR0ReqCyc", txReq,       32'd2);
        check("ldR0WbData", WbDataOut,   32'h0000_0011);
        check("ldR0WbEn",   WbEnableOut, 32'h0);
        @(negedge clk);
        clearOps();

        // Minimum-latency load: ack in the first request cycle.
        memTxn(1'b1, 32'h0000_0300, 32'h0, 5'd3, 5'd10, 1'b0, 1'b1, 1, 32'h0BAD_F00D);
        check("ldMinStall",  txStall,     32'd1);
        check("ldMinWbData", WbDataOut,   32'h0BAD_F00D);
        check("ldMinWbReg",  WbRegOut,    32'd10);
        check("ldMinWbEn",   WbEnableOut, 32'h1);
        @(negedge clk);
        clearOps();

        // Ack in IDLE is ignored, then reset lands mid-access.
        IsLoadInsnIn = 1'b1; ALUOutIn = 32'h0000_0400; RDIn = 5'd3; IsDstRtIn = 1'b0; RdWrEnableIn = 1'b1;
        dmemAck = 1'b1;
        #1;
        check("idleAckStall", StallOut, 32'h1);
        @(posedge clk);
        #1;
        check("idleAckIssue", dmemReq,     32'h1);
        check("idleAckBubble", WbEnableOut, 32'h0);
        @(negedge clk);
        dmemAck = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midRstReq",  dmemReq,     32'h0);
        check("midRstAddr", dmemAddr,    32'h0);
        check("midRstWbEn", WbEnableOut, 32'h0);
        clearOps();
        @(negedge clk);
        rst = 1'b0;
        ALUOutIn = 32'h0000_0077; RDIn = 5'd8; IsDstRtIn = 1'b0; RdWrEnableIn = 1'b1;
        dmemAck = 1'b1;
        #1;
        check("lateAckStall", StallOut, 32'h0);
        @(posedge clk);
        #1;
        check("lateAckReq",    dmemReq,     32'h0);
        check("lateAckWbData", WbDataOut,   32'h0000_0077);
        check("lateAckWbEn",   WbEnableOut, 32'h1);
        @(negedge clk);
        dmemAck = 1'b0;
        memTxn(1'b1, 32'h0000_0500, 32'h0, 5'd0, 5'd2, 1'b0, 1'b1, 1, 32'h0000_003C);
        check("postRstDone",   txDone,    32'h1);
        check("postRstReqCyc", txReq,     32'd1);
        check("postRstWbData", WbDataOut, 32'h0000_003C);
        @(negedge clk);
        clearOps();

        // Access that is never acknowledged.
        IsLoadInsnIn = 1'b1; ALUOutIn = 32'h0000_0600; RDIn = 5'd4; IsDstRtIn = 1'b0; RdWrEnableIn = 1'b1;
`ifdef MEM_TIMEOUT_EN
        begin
            int reqCyc;
            int stallLowAt;
            reqCyc     = 0;
            stallLowAt = -1;
            @(posedge clk);
            for (int c = 0; c < 400; c++) begin
                @(negedge clk);
                if (!dmemReq) break;
                reqCyc++;
                if (!StallOut && stallLowAt < 0) stallLowAt = reqCyc;
            end
            check("toReqCyc",   reqCyc,      32'd255);
            check("toStallLow", stallLowAt,  32'd255);
            check("toReqOff",   dmemReq,     32'h0);
            check("toErr",      MemErrOut,   32'h1);
            check("toWbEn",     WbEnableOut, 32'h0);
            clearOps();
            repeat (3) @(negedge clk);
            check("toErrSticky", MemErrOut, 32'h1);
            rst = 1'b1;
            #1;
            check("toErrRst", MemErrOut, 32'h0);
        end
`else
        repeat (1000) @(negedge clk);
        check("noToReq",   dmemReq,   32'h1);
        check("noToStall", StallOut,  32'h1);
        check("noToErr",   MemErrOut, 32'h0);
        rst = 1'b1;
        #1;
        check("noToRstReq", dmemReq, 32'h0);
`endif
        clearOps();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
